hazard_stall_unit: RTL

//  Producer-side counterpart of operand forwarding in the 5-stage RV32I pipeline: handles the hazards forwarding cannot resolve.

---
 rtl/hazard_stall_unit_pkg.sv | 27 ++
 rtl/hazard_stall_unit_sat.sv | 19 +
 rtl/hazard_stall_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: state encoding,
// register constants and the bundle of stage enables/flushes.
package hazard_stall_unit_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN      = stage_ctrl_t'(7'b1111100);
    localparam stage_ctrl_t CTRL_HOLD_ALL = stage_ctrl_t'(7'b0000000);
    // Front end frozen, a bubble slides into EX while older stages drain.
    localparam stage_ctrl_t CTRL_LU_STALL = stage_ctrl_t'(7'b0011101);
    localparam stage_ctrl_t CTRL_FLUSH    = stage_ctrl_t'(7'b1111111);

endpackage

// File: rtl/hazard_stall_unit_sat.sv
// Saturating up-counter: increments on inc, sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller for the 5-stage RV32I pipeline: load-use bubbles,
// taken-branch flushes and data-memory wait states, plus stall/flush counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic             IF_ID_UseRS1,
    input  logic             IF_ID_UseRS2,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             EX_MEM_MemAccess,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam bit         LU_MULTI  = (LOAD_STALL_CYCLES > 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  lu_cnt;
    logic [2:0]  lu_cnt_nxt;
    logic        load_use;
    logic        mem_wait;
    logic        in_lu_stall;
    logic        stall_inc;
    logic        flush_inc;
    stage_ctrl_t ctrl;

    assign load_use = ID_EX_MemRead && (ID_EX_Rd != REG_X0) &&
                      ((IF_ID_UseRS1 && (ID_EX_Rd == IF_ID_RS1)) ||
                       (IF_ID_UseRS2 && (ID_EX_Rd == IF_ID_RS2)));

    assign mem_wait = EX_MEM_MemAccess && !dmem_ready;

    // Leaving MEM_WAIT resumes an interrupted load-use stall if bubbles remain.
    assign in_lu_stall = (state == ST_LU_STALL) ||
                         ((state == ST_MEM_WAIT) && (lu_cnt != 3'd0));

    always_comb begin
        ctrl       = CTRL_RUN;
        state_nxt  = ST_RUN;
        lu_cnt_nxt = lu_cnt;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (mem_wait) begin
            ctrl      = CTRL_HOLD_ALL;
            state_nxt = ST_MEM_WAIT;
            stall_inc = 1'b1;
        end else if (EX_BranchTaken) begin
            ctrl       = CTRL_FLUSH;
            flush_inc  = 1'b1;
            lu_cnt_nxt = 3'd0;
        end else if (in_lu_stall) begin
            ctrl       = CTRL_LU_STALL;
            stall_inc  = 1'b1;
            lu_cnt_nxt = lu_cnt - 3'd1;
            state_nxt  = (lu_cnt == 3'd1) ? ST_RUN : ST_LU_STALL;
        end else if (load_use) begin
            ctrl      = CTRL_LU_STALL;
            stall_inc = 1'b1;
            if (LU_MULTI) begin
                lu_cnt_nxt = LU_RELOAD;
                state_nxt  = ST_LU_STALL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            lu_cnt <= 3'd0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    // Reset overrides everything combinationally: freeze all stages, flush the front.
    assign pc_write     = rst_n && ctrl.pc_write;
    assign if_id_write  = rst_n && ctrl.if_id_write;
    assign id_ex_write  = rst_n && ctrl.id_ex_write;
    assign ex_mem_write = rst_n && ctrl.ex_mem_write;
    assign mem_wb_write = rst_n && ctrl.mem_wb_write;
    assign if_id_flush  = !rst_n || ctrl.if_id_flush;
    assign id_ex_flush  = !rst_n || ctrl.id_ex_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .q     (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .q     (flush_count)
    );

endmodule
